// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sequential divider between NUM_REQ requesters.
// Latency: req sampled in IDLE -> div start next cycle -> done one cycle after div_ready is seen (div-by-zero: done 2 cycles after sample).
// Backpressure: requesters hold req until their done pulse; the arbiter serves one request at a time.
// Optional feature: define DIV_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module div_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BITS           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ*BITS-1:0] req_dividendo_i,
  input  logic [NUM_REQ*BITS-1:0] req_divisor_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [BITS-1:0]         result_o,
  output logic                    div_err_o,
  output logic                    div_reset_o,
  output logic [BITS-1:0]         div_dividendo_o,
  output logic [BITS-1:0]         div_divisor_o,
  input  logic                    div_ready_i,
  input  logic [BITS-1:0]         div_result_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("div_arbiter: NUM_REQ must be in 2..8");
  end
  if (BITS < 1) begin : g_bad_bits
    $error("div_arbiter: BITS must be positive");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("div_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [BITS-1:0]     result_q;
  logic                err_q;
  logic [BITS-1:0]     dvd_q;
  logic [BITS-1:0]     dvs_q;
  logic                guard_q;

  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       cand;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                cap_ok;
  logic                force_err;

`ifdef DIV_ARB_TIMEOUT_EN
  // Counter width is independent of BITS: 8 bits when the limit fits, else 16.
  localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
`endif

  // Round-robin pick: first requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cap_ok/force_err mark how the result is produced on entry to DONE.
  always_comb begin
    state_d   = state_q;
    cap_ok    = 1'b0;
    force_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (dvs_q == '0) begin
          force_err = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The first WAIT cycle may still see div_ready from the previous operation.
        if (!guard_q && div_ready_i) begin
          cap_ok  = 1'b1;
          state_d = DONE;
        end
`ifdef DIV_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          force_err = 1'b1;
          state_d   = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant, owner, operand latch, result capture and round-robin pointer update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      guard_q  <= 1'b0;
    end else begin
      guard_q <= (state_q == LAUNCH);
      if (state_q == IDLE && pick_vld) begin
        grant_q <= pick_oh;
        owner_q <= pick_idx;
        dvd_q   <= req_dividendo_i[int'(pick_idx)*BITS +: BITS];
        dvs_q   <= req_divisor_i[int'(pick_idx)*BITS +: BITS];
      end
      if (cap_ok) begin
        result_q <= div_result_i;
        err_q    <= 1'b0;
      end else if (force_err) begin
        result_q <= '1;
        err_q    <= 1'b1;
      end
      if (state_q == DONE) begin
        grant_q  <= '0;
        rr_ptr_q <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  // Watchdog: counts WAIT cycles, cleared in every other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`endif

  assign grant_o         = grant_q;
  assign done_o          = (state_q == DONE) ? grant_q : '0;
  assign result_o        = result_q;
  assign div_err_o       = (state_q == DONE) && err_q;
  assign div_reset_o     = (state_q == LAUNCH) && (dvs_q != '0);
  assign div_dividendo_o = dvd_q;
  assign div_divisor_o   = dvs_q;

endmodule
